// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks (write and read side).
package fifo_pkg;

  // Number of entries for a given address width.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Binary to Gray; callers zero-extend narrower pointers and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary; upper bits beyond the pointer width must be zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i + 1] ^ g[i];
    end
    return b;
  endfunction

  // Gray pointer that is exactly DEPTH ahead of g: the top two bits of a width-w
  // pointer are inverted, the rest are equal.
  function automatic logic [31:0] full_cmp(input logic [31:0] g, input int unsigned w);
    return g ^ (32'd3 << (w - 2));
  endfunction

endpackage

// File: rtl/gray_ptr_cnt.sv
// Binary + Gray pointer register pair with increment enable and async reset.
module gray_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] bin_next,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] w_bin_next;

  // Next pointer wraps naturally modulo 2**WIDTH.
  always_comb begin
    w_bin_next = r_bin + WIDTH'(inc);
  end

  // Gray copy comes straight from a flop so it is glitch-free across the CDC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= WIDTH'(bin2gray(32'(w_bin_next)));
    end
  end

  assign bin      = r_bin;
  assign bin_next = w_bin_next;
  assign gray     = r_gray;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full/overflow flags and fill level for the async FIFO.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   wr_level
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;
  logic [PW-1:0] r_level;

  logic          w_accept;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_level_next;
  logic          w_full_next;
  logic          w_af_next;

  assign w_accept = wr_en & ~r_full;

  gray_ptr_cnt #(
    .WIDTH (PW)
  ) u_wptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_accept),
    .bin      (w_wbin),
    .bin_next (w_wbin_next),
    .gray     (wr_ptr_gray)
  );

  // Flag and level next-state, all relative to the pointer after this cycle's write.
  always_comb begin
    w_wgray_next = PW'(bin2gray(32'(w_wbin_next)));
    w_rbin       = PW'(gray2bin(32'(rd_ptr_gray_sync)));
    w_full_next  = (w_wgray_next == PW'(full_cmp(32'(rd_ptr_gray_sync), PW)));
    w_level_next = w_wbin_next - w_rbin;
    w_af_next    = (w_level_next >= PW'(DEPTH - AF_THRESH));
  end

  // Registered flags; overflow is a one-cycle pulse per rejected write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
      r_level       <= '0;
    end else begin
      r_full        <= w_full_next;
      r_almost_full <= w_af_next;
      r_overflow    <= wr_en & r_full;
      r_level       <= w_level_next;
    end
  end

  assign mem_we      = w_accept;
  assign wr_addr     = w_wbin[ADDR_WIDTH-1:0];
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;
  assign wr_level    = r_level;

endmodule
